dot4_stream_q16: RTL

- Streaming 4-element dot-product responder for the matrix/vector math path.
- Accepts one signed fixed-point operand pair per cycle from an element feeder (the sequencer that walks matrix rows against vector columns).
- Emits one saturated dot product after every 4th accepted pair.
- Fixed-point replacement for the vendor pipelined dot core: deterministic latency, no IP dependency, synthesizable in fabric DSPs.

---
 rtl/dot4_stream_q16_pkg.sv | 13 +
 rtl/dot4_stream_q16_if.sv | 25 ++
 rtl/dot4_stream_q16_q_shift_sat.sv | 30 +++
 rtl/dot4_stream_q16.sv | 86 ++++++++
 4 files changed

// File: rtl/dot4_stream_q16_pkg.sv
// Shared fixed-point math constants for the Q-format datapath blocks.
package dot4_stream_q16_pkg;

  localparam int unsigned FRAC_BITS_DEF = 16;
  localparam int unsigned Q_W           = 32;
  localparam int unsigned PROD_W        = 64;
  localparam int unsigned ACC_W         = 66;

  localparam logic [Q_W-1:0] Q_ONE = 32'h1 << FRAC_BITS_DEF;
  localparam logic [Q_W-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [Q_W-1:0] Q_MIN = 32'h8000_0000;

endpackage

// File: rtl/dot4_stream_q16_if.sv
// Operand-pair stream in, dot-product result out.
//   master: element feeder (drives in_valid/in_a/in_b/restart)
//   slave : dot-product responder (drives out_valid/out_result/out_sat/busy)
interface dot4_stream_q16_if;
  import dot4_stream_q16_pkg::*;

  logic                  in_valid;
  logic signed [Q_W-1:0] in_a;
  logic signed [Q_W-1:0] in_b;
  logic                  restart;
  logic                  out_valid;
  logic [Q_W-1:0]        out_result;
  logic                  out_sat;
  logic                  busy;

  modport master (
    output in_valid, in_a, in_b, restart,
    input  out_valid, out_result, out_sat, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, restart,
    output out_valid, out_result, out_sat, busy
  );
endinterface

// File: rtl/dot4_stream_q16_q_shift_sat.sv
// Combinational Q-format narrowing: 66-bit accumulator, arithmetic shift
// right by FRAC_BITS (floor), then clamp to the signed 32-bit range.
//   din  : signed accumulator value
//   dout : shifted and clamped Q result
//   sat  : high when dout was clamped
module dot4_stream_q16_q_shift_sat
  import dot4_stream_q16_pkg::*;
#(
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic signed [ACC_W-1:0] din,
  output logic [Q_W-1:0]          dout,
  output logic                    sat
);

  logic signed [ACC_W-1:0] shifted_c;
  logic                    fits_c;

  // Value fits in 32 bits when every bit above bit 30 matches the sign.
  always_comb begin
    shifted_c = din >>> FRAC_BITS;
    fits_c    = (&shifted_c[ACC_W-1:Q_W-1]) || (~|shifted_c[ACC_W-1:Q_W-1]);
    sat       = !fits_c;
    dout      = shifted_c[Q_W-1:0];
    if (!fits_c) begin
      dout = shifted_c[ACC_W-1] ? Q_MIN : Q_MAX;
    end
  end

endmodule

// File: rtl/dot4_stream_q16.sv
// Streaming 4-element signed fixed-point dot product.
// Stage 1 registers the full 64-bit product with group tags, stage 2
// accumulates in 66 bits and emits a saturated result on the 4th element.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   bus (slave)  : in_valid/in_a/in_b/restart in,
//                  out_valid/out_result/out_sat/busy out
module dot4_stream_q16
  import dot4_stream_q16_pkg::*;
#(
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input logic              clock,
  input logic              reset,
  dot4_stream_q16_if.slave bus
);

  logic [1:0]               idx;
  logic signed [PROD_W-1:0] prod;
  logic                     p_valid;
  logic                     p_first;
  logic                     p_last;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next_c;
  logic [Q_W-1:0]           sat_res_c;
  logic                     sat_flag_c;

  // Stage 1: multiply and tag group position; restart re-bases the group.
  always_ff @(posedge clock) begin
    if (!reset) begin
      idx     <= 2'd0;
      prod    <= '0;
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
    end else begin
      p_valid <= bus.in_valid;
      if (bus.in_valid) begin
        prod    <= PROD_W'(bus.in_a) * PROD_W'(bus.in_b);
        p_first <= bus.restart || (idx == 2'd0);
        p_last  <= !bus.restart && (idx == 2'd3);
      end
      if (bus.restart) begin
        idx <= bus.in_valid ? 2'd1 : 2'd0;
      end else if (bus.in_valid) begin
        idx <= idx + 2'd1;
      end
    end
  end

  // First element of a group overwrites the accumulator.
  always_comb begin
    acc_next_c = p_first ? ACC_W'(prod) : acc + ACC_W'(prod);
  end

  dot4_stream_q16_q_shift_sat #(
    .FRAC_BITS (FRAC_BITS)
  ) u_shift_sat (
    .din  (acc_next_c),
    .dout (sat_res_c),
    .sat  (sat_flag_c)
  );

  // Stage 2: accumulate and publish on the last element.
  always_ff @(posedge clock) begin
    if (!reset) begin
      acc            <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_sat    <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (p_valid) begin
        acc <= acc_next_c;
        if (p_last) begin
          bus.out_result <= sat_res_c;
          bus.out_sat    <= sat_flag_c;
          bus.out_valid  <= 1'b1;
        end
      end
    end
  end

  // A pending stage-2 output write is always carried by p_valid.
  assign bus.busy = (idx != 2'd0) || p_valid;

endmodule
